// File: rtl/fp_cmp_result_stage.sv
// FPU compare result stage: applies IEEE-754 / RISC-V NaN rules to raw comparator flags and
// selects FEQ/FLT/FLE/FMIN/FMAX results through a two-stage valid/ready pipeline.
module fp_cmp_result_stage #(
    parameter int TAG_W  = 5,
    parameter int PIPE_D = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_sp_dp,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic             in_eq,
    input  logic             in_lt,
    input  logic             in_le,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [4:0]       out_fflags,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        OP_FEQ  = 3'd0,
        OP_FLT  = 3'd1,
        OP_FLE  = 3'd2,
        OP_FMIN = 3'd3,
        OP_FMAX = 3'd4
    } op_e;

    localparam logic [63:0] SP_CANON = 64'hFFFF_FFFF_7FC0_0000;
    localparam logic [63:0] DP_CANON = 64'h7FF8_0000_0000_0000;

    typedef struct packed {
        logic        nan;
        logic        snan;
        logic        zero;
        logic        sign;
        logic [63:0] val;
    } opnd_t;

    // An improperly NaN-boxed single operand is replaced by the canonical quiet NaN.
    function automatic opnd_t classify(input logic [63:0] x, input logic dp);
        opnd_t c;
        c.val  = x;
        c.sign = dp ? x[63] : x[31];
        if (dp) begin
            c.nan  = (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
            c.snan = c.nan && !x[51];
            c.zero = (x[62:0] == 63'd0);
        end else if (x[63:32] != 32'hFFFF_FFFF) begin
            c.nan  = 1'b1;
            c.snan = 1'b0;
            c.zero = 1'b0;
            c.sign = 1'b0;
            c.val  = SP_CANON;
        end else begin
            c.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
            c.snan = c.nan && !x[22];
            c.zero = (x[30:0] == 31'd0);
        end
        return c;
    endfunction

    logic [PIPE_D-1:0] valid_q, valid_d;

    logic [2:0]       s1_op_q, s1_op_d;
    logic             s1_dp_q, s1_dp_d;
    logic [63:0]      s1_a_q, s1_a_d;
    logic [63:0]      s1_b_q, s1_b_d;
    logic             s1_eq_q, s1_eq_d;
    logic             s1_lt_q, s1_lt_d;
    logic             s1_le_q, s1_le_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic [63:0]      s2_result_q, s2_result_d;
    logic [4:0]       s2_fflags_q, s2_fflags_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic s1_adv, s2_adv, accept, s2_load;
    opnd_t opa, opb;
    logic [63:0] sel_result;
    logic        sel_nv;

    always_comb begin
        s2_adv  = !valid_q[PIPE_D-1] || out_ready;
        s1_adv  = !valid_q[0] || s2_adv;
        accept  = in_valid && s1_adv && !flush;
        s2_load = s2_adv && valid_q[0] && !flush;
    end

    assign in_ready = s1_adv;

    always_comb begin
        opa        = classify(s1_a_q, s1_dp_q);
        opb        = classify(s1_b_q, s1_dp_q);
        sel_result = 64'd0;
        sel_nv     = 1'b0;
        case (s1_op_q)
            OP_FEQ: begin
                sel_result = {63'd0, !(opa.nan || opb.nan) && s1_eq_q};
                sel_nv     = opa.snan || opb.snan;
            end
            OP_FLT: begin
                sel_result = {63'd0, !(opa.nan || opb.nan) && s1_lt_q};
                sel_nv     = opa.nan || opb.nan;
            end
            OP_FLE: begin
                sel_result = {63'd0, !(opa.nan || opb.nan) && s1_le_q};
                sel_nv     = opa.nan || opb.nan;
            end
            OP_FMIN, OP_FMAX: begin
                sel_nv = opa.snan || opb.snan;
                if (opa.nan && opb.nan) begin
                    sel_result = s1_dp_q ? DP_CANON : SP_CANON;
                end else if (opa.nan) begin
                    sel_result = opb.val;
                end else if (opb.nan) begin
                    sel_result = opa.val;
                end else if (opa.zero && opb.zero && (opa.sign != opb.sign)) begin
                    // The raw lt flag sees -0 == +0, so the sign decides here.
                    sel_result = ((s1_op_q == OP_FMIN) == opa.sign) ? opa.val : opb.val;
                end else begin
                    sel_result = ((s1_op_q == OP_FMIN) == s1_lt_q) ? opa.val : opb.val;
                end
            end
            default: begin
                sel_result = 64'd0;
                sel_nv     = 1'b0;
            end
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        s1_op_d     = s1_op_q;
        s1_dp_d     = s1_dp_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_eq_d     = s1_eq_q;
        s1_lt_d     = s1_lt_q;
        s1_le_d     = s1_le_q;
        s1_tag_d    = s1_tag_q;
        s2_result_d = s2_result_q;
        s2_fflags_d = s2_fflags_q;
        s2_tag_d    = s2_tag_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (s1_adv) valid_d[0] = accept;
            if (s2_adv) valid_d[PIPE_D-1] = valid_q[0];
        end
        if (accept) begin
            s1_op_d  = in_op;
            s1_dp_d  = in_sp_dp;
            s1_a_d   = in_a;
            s1_b_d   = in_b;
            s1_eq_d  = in_eq;
            s1_lt_d  = in_lt;
            s1_le_d  = in_le;
            s1_tag_d = in_tag;
        end
        if (s2_load) begin
            s2_result_d = sel_result;
            s2_fflags_d = {sel_nv, 4'b0000};
            s2_tag_d    = s1_tag_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            s1_op_q     <= 3'd0;
            s1_dp_q     <= 1'b0;
            s1_a_q      <= 64'd0;
            s1_b_q      <= 64'd0;
            s1_eq_q     <= 1'b0;
            s1_lt_q     <= 1'b0;
            s1_le_q     <= 1'b0;
            s1_tag_q    <= '0;
            s2_result_q <= 64'd0;
            s2_fflags_q <= 5'd0;
            s2_tag_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            s1_op_q     <= s1_op_d;
            s1_dp_q     <= s1_dp_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_eq_q     <= s1_eq_d;
            s1_lt_q     <= s1_lt_d;
            s1_le_q     <= s1_le_d;
            s1_tag_q    <= s1_tag_d;
            s2_result_q <= s2_result_d;
            s2_fflags_q <= s2_fflags_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    assign out_valid  = valid_q[PIPE_D-1];
    assign out_result = s2_result_q;
    assign out_fflags = s2_fflags_q;
    assign out_tag    = s2_tag_q;

endmodule

// File: tb/tb_fp_cmp_result_stage.sv
// Self-checking bench for fp_cmp_result_stage: directed corner cases, pipeline stall/flush/reset
// scenarios and a randomized stream scored against a behavioural model.
module tb_fp_cmp_result_stage;

    localparam int TAG_W = 5;
    localparam logic [63:0] SP_CANON = 64'hFFFF_FFFF_7FC0_0000;
    localparam logic [63:0] DP_CANON = 64'h7FF8_0000_0000_0000;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, in_sp_dp;
    logic             in_eq, in_lt, in_le, out_valid, out_ready;
    logic [2:0]       in_op;
    logic [63:0]      in_a, in_b, out_result;
    logic [4:0]       out_fflags;
    logic [TAG_W-1:0] in_tag, out_tag;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [63:0]      res;
        logic [4:0]       flags;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];

    fp_cmp_result_stage #(.TAG_W(TAG_W), .PIPE_D(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_sp_dp(in_sp_dp),
        .in_a(in_a), .in_b(in_b), .in_eq(in_eq), .in_lt(in_lt), .in_le(in_le), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_fflags(out_fflags), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Reference model: decode each operand into IEEE fields with plain arithmetic.
    function automatic bit m_badbox(logic [63:0] x, bit dp);
        return !dp && (x[63:32] != 32'hFFFF_FFFF);
    endfunction

    function automatic bit m_nan(logic [63:0] x, bit dp);
        longint unsigned e, m;
        if (m_badbox(x, dp)) return 1'b1;
        e = dp ? ((x >> 52) & 64'h7FF) : ((x >> 23) & 64'hFF);
        m = dp ? (x & ((64'd1 << 52) - 64'd1)) : (x & ((64'd1 << 23) - 64'd1));
        return (e == (dp ? 64'h7FF : 64'hFF)) && (m != 0);
    endfunction

    function automatic bit m_snan(logic [63:0] x, bit dp);
        longint unsigned q;
        if (!m_nan(x, dp) || m_badbox(x, dp)) return 1'b0;
        q = dp ? ((x >> 51) & 64'd1) : ((x >> 22) & 64'd1);
        return q == 0;
    endfunction

    function automatic bit m_zero(logic [63:0] x, bit dp);
        if (m_badbox(x, dp)) return 1'b0;
        return dp ? ((x & 64'h7FFF_FFFF_FFFF_FFFF) == 0) : ((x & 64'h7FFF_FFFF) == 0);
    endfunction

    function automatic bit m_neg(logic [63:0] x, bit dp);
        return dp ? ((x >> 63) != 0) : (((x >> 31) & 64'd1) != 0);
    endfunction

    function automatic exp_t ref_model(logic [2:0] op, bit dp, logic [63:0] a, logic [63:0] b,
                                       bit eq, bit lt, bit le, logic [TAG_W-1:0] tag);
        exp_t e;
        bit na, nb, sa, sb, nv;
        na = m_nan(a, dp);
        nb = m_nan(b, dp);
        sa = m_snan(a, dp);
        sb = m_snan(b, dp);
        e.res = 64'd0;
        e.tag = tag;
        nv = 1'b0;
        if (op == 3'd0) begin
            nv = sa | sb;
            e.res = (na | nb) ? 64'd0 : 64'(eq);
        end else if (op == 3'd1 || op == 3'd2) begin
            nv = na | nb;
            e.res = (na | nb) ? 64'd0 : 64'((op == 3'd1) ? lt : le);
        end else if (op == 3'd3 || op == 3'd4) begin
            nv = sa | sb;
            if (na && nb) e.res = dp ? DP_CANON : SP_CANON;
            else if (na) e.res = b;
            else if (nb) e.res = a;
            else if (m_zero(a, dp) && m_zero(b, dp) && (m_neg(a, dp) != m_neg(b, dp)))
                e.res = (m_neg(a, dp) == (op == 3'd3)) ? a : b;
            else
                e.res = (lt == (op == 3'd3)) ? a : b;
        end
        e.flags = nv ? 5'b10000 : 5'b00000;
        return e;
    endfunction

    function automatic logic [63:0] gen_opnd(bit dp);
        int k;
        logic s;
        logic [63:0] r;
        logic [50:0] m51;
        logic [21:0] m22;
        k = $urandom_range(0, 6);
        s = 1'($urandom_range(0, 1));
        m51 = {19'($urandom), 32'($urandom)};
        if (m51 == 0) m51 = 51'd1;
        m22 = 22'($urandom);
        if (m22 == 0) m22 = 22'd1;
        if (dp) begin
            case (k)
                0: r = {$urandom, $urandom};
                1: r = {s, 63'd0};
                2: r = {s, 11'h7FF, 1'b1, 51'($urandom)};
                3: r = {s, 11'h7FF, 1'b0, m51};
                4: r = {s, 11'h7FF, 52'd0};
                default: r = {s, 11'($urandom_range(1, 2046)), 20'($urandom), 32'($urandom)};
            endcase
        end else begin
            r[63:32] = 32'hFFFF_FFFF;
            case (k)
                0: r[31:0] = $urandom;
                1: r[31:0] = {s, 31'd0};
                2: r[31:0] = {s, 8'hFF, 1'b1, 22'($urandom)};
                3: r[31:0] = {s, 8'hFF, 1'b0, m22};
                4: r[31:0] = {s, 8'hFF, 23'd0};
                5: begin
                    r[63:32] = $urandom;
                    if (r[63:32] == 32'hFFFF_FFFF) r[63:32] = 32'd0;
                    r[31:0] = $urandom;
                end
                default: r[31:0] = {s, 8'($urandom_range(1, 254)), 23'($urandom)};
            endcase
        end
        return r;
    endfunction

    // Drives one op into an idle pipe, then corrupts the inputs; returns what the DUT emitted.
    task automatic run_op(input logic [2:0] op, input logic dp, input logic [63:0] a,
                          input logic [63:0] b, input logic eq, input logic lt, input logic le,
                          input logic [TAG_W-1:0] tag, output logic [63:0] res,
                          output logic [4:0] fl, output logic [TAG_W-1:0] tg, output int lat);
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_sp_dp = dp; in_a = a; in_b = b;
        in_eq = eq; in_lt = lt; in_le = le; in_tag = tag; out_ready = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_eq = ~eq; in_lt = ~lt; in_le = ~le; in_a = ~a; in_b = ~b;
        lat = -1;
        res = 64'd0; fl = 5'd0; tg = '0;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k; res = out_result; fl = out_fflags; tg = out_tag;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (out_result !== 64'd0) $display("[TB] FAIL reset_out_result: got %h expected 0", out_result); else passes++;
        checks++; if (out_fflags !== 5'd0) $display("[TB] FAIL reset_out_fflags: got %h expected 0", out_fflags); else passes++;
        checks++; if (out_tag !== '0) $display("[TB] FAIL reset_out_tag: got %h expected 0", out_tag); else passes++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_flt_sp();
        logic [63:0] r; logic [4:0] f; logic [TAG_W-1:0] t; int lat;
        run_op(3'd1, 1'b0, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_4000_0000, 1'b0, 1'b1, 1'b1,
               5'd9, r, f, t, lat);
        checks++; if (lat !== 2) $display("[TB] FAIL flt_latency: got %0d expected 2", lat); else passes++;
        checks++; if (r !== 64'd1) $display("[TB] FAIL flt_result: got %h expected 1", r); else passes++;
        checks++; if (f !== 5'd0) $display("[TB] FAIL flt_fflags: got %h expected 0", f); else passes++;
        checks++; if (t !== 5'd9) $display("[TB] FAIL flt_tag: got %h expected 09", t); else passes++;
    endtask

    task automatic test_feq_nan();
        logic [63:0] r; logic [4:0] f; logic [TAG_W-1:0] t; int lat;
        run_op(3'd0, 1'b1, 64'h7FF4_0000_0000_0000, 64'h7FF4_0000_0000_0000, 1'b1, 1'b0, 1'b1,
               5'd3, r, f, t, lat);
        checks++; if (r !== 64'd0) $display("[TB] FAIL feq_snan_result: got %h expected 0", r); else passes++;
        checks++; if (f !== 5'h10) $display("[TB] FAIL feq_snan_fflags: got %h expected 10", f); else passes++;
        run_op(3'd0, 1'b1, 64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000, 1'b1, 1'b0, 1'b1,
               5'd4, r, f, t, lat);
        checks++; if (r !== 64'd0) $display("[TB] FAIL feq_qnan_result: got %h expected 0", r); else passes++;
        checks++; if (f !== 5'h00) $display("[TB] FAIL feq_qnan_fflags: got %h expected 00", f); else passes++;
        run_op(3'd2, 1'b1, 64'h7FF8_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 1'b1, 1'b1,
               5'd5, r, f, t, lat);
        checks++; if ({r, f} !== {64'd0, 5'h10}) $display("[TB] FAIL fle_qnan: got %h/%h expected 0/10", r, f); else passes++;
    endtask

    task automatic test_fminmax_zero();
        logic [63:0] r; logic [4:0] f; logic [TAG_W-1:0] t; int lat;
        run_op(3'd3, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0, 1'b1,
               5'd6, r, f, t, lat);
        checks++; if (r !== 64'hFFFF_FFFF_8000_0000) $display("[TB] FAIL fmin_zero: got %h expected ffffffff80000000", r); else passes++;
        run_op(3'd4, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0, 1'b1,
               5'd7, r, f, t, lat);
        checks++; if (r !== 64'hFFFF_FFFF_0000_0000) $display("[TB] FAIL fmax_zero: got %h expected ffffffff00000000", r); else passes++;
        run_op(3'd3, 1'b1, 64'h7FF4_0000_0000_0000, 64'hFFF0_0000_0000_0001, 1'b0, 1'b0, 1'b0,
               5'd8, r, f, t, lat);
        checks++; if ({r, f} !== {DP_CANON, 5'h10}) $display("[TB] FAIL fmin_both_nan: got %h/%h expected %h/10", r, f, DP_CANON); else passes++;
    endtask

    task automatic test_bad_box();
        logic [63:0] r; logic [4:0] f; logic [TAG_W-1:0] t; int lat;
        run_op(3'd4, 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_4000_0000, 1'b0, 1'b1, 1'b1,
               5'd10, r, f, t, lat);
        checks++; if (r !== 64'hFFFF_FFFF_4000_0000) $display("[TB] FAIL badbox_result: got %h expected ffffffff40000000", r); else passes++;
        checks++; if (f !== 5'd0) $display("[TB] FAIL badbox_fflags: got %h expected 0", f); else passes++;
    endtask

    task automatic test_reserved();
        logic [63:0] r; logic [4:0] f; logic [TAG_W-1:0] t; int lat;
        run_op(3'd6, 1'b1, 64'h7FF4_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 1'b1, 1'b1,
               5'd21, r, f, t, lat);
        checks++; if (lat !== 2) $display("[TB] FAIL reserved_latency: got %0d expected 2", lat); else passes++;
        checks++; if ({r, f, t} !== {64'd0, 5'd0, 5'd21}) $display("[TB] FAIL reserved_out: got %h/%h/%h expected 0/0/15", r, f, t); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops[4];
        logic        dps[4];
        logic [63:0] as[4], bs[4];
        logic [2:0]  flg[4];
        int idx, got;
        logic prev_stall;
        logic [63:0] p_res; logic [4:0] p_fl; logic [TAG_W-1:0] p_tag;
        exp_t e;
        ops = '{3'd1, 3'd0, 3'd4, 3'd3};
        dps = '{1'b0, 1'b1, 1'b0, 1'b0};
        as  = '{64'hFFFF_FFFF_3F80_0000, 64'h7FF4_0000_0000_0000, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_8000_0000};
        bs  = '{64'hFFFF_FFFF_4000_0000, 64'h7FF4_0000_0000_0000, 64'hFFFF_FFFF_4000_0000, 64'hFFFF_FFFF_0000_0000};
        flg = '{3'b011, 3'b101, 3'b011, 3'b101};
        exp_q.delete();
        idx = 0; got = 0; prev_stall = 1'b0;
        p_res = 64'd0; p_fl = 5'd0; p_tag = '0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            @(posedge clk); #1;
            flush = 1'b0;
            out_ready = (cyc >= 4);
            if (idx < 4) begin
                in_valid = 1'b1; in_op = ops[idx]; in_sp_dp = dps[idx]; in_a = as[idx]; in_b = bs[idx];
                {in_eq, in_lt, in_le} = flg[idx]; in_tag = 5'(idx + 16);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc == 2 || cyc == 3) begin
                checks++; if (in_ready !== 1'b0 || idx !== 2) $display("[TB] FAIL b2b_ready_drop: got ready=%b accepts=%0d expected ready=0 accepts=2", in_ready, idx); else passes++;
            end
            if (prev_stall) begin
                checks++;
                if ({out_valid, out_result, out_fflags, out_tag} !== {1'b1, p_res, p_fl, p_tag})
                    $display("[TB] FAIL b2b_hold: got %b/%h/%h/%h expected 1/%h/%h/%h", out_valid, out_result, out_fflags, out_tag, p_res, p_fl, p_tag);
                else passes++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_op, in_sp_dp, in_a, in_b, in_eq, in_lt, in_le, in_tag));
                idx++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL b2b_extra: got unexpected result %h tag %h", out_result, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_result, out_fflags, out_tag} !== {e.res, e.flags, e.tag})
                        $display("[TB] FAIL b2b_result: got %h/%h/%h expected %h/%h/%h", out_result, out_fflags, out_tag, e.res, e.flags, e.tag);
                    else passes++;
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            p_res = out_result; p_fl = out_fflags; p_tag = out_tag;
        end
        checks++; if (got !== 4 || idx !== 4) $display("[TB] FAIL b2b_count: got delivered=%0d accepted=%0d expected 4/4", got, idx); else passes++;
    endtask

    task automatic test_reset_flush();
        int seen;
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = 3'd1; in_sp_dp = 1'b0; in_a = 64'hFFFF_FFFF_3F80_0000;
        in_b = 64'hFFFF_FFFF_4000_0000; {in_eq, in_lt, in_le} = 3'b011; in_tag = 5'd1;
        out_ready = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL async_reset: got valid=%b ready=%b expected 0/1", out_valid, in_ready); else passes++;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b1; in_tag = 5'd2;
        @(posedge clk); #1;
        flush = 1'b1; in_tag = 5'd3;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL flush_in_ready: got %b expected 1", in_ready); else passes++;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) $display("[TB] FAIL flush_no_emit: got %0d results expected 0", seen); else passes++;
    endtask

    task automatic test_random();
        exp_t e;
        int drained, bad;
        exp_q.delete();
        drained = 0; bad = 0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(posedge clk); #1;
            flush = 1'b0;
            if (cyc < 400) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                in_op     = 3'($urandom_range(0, 7));
                in_sp_dp  = 1'($urandom_range(0, 1));
                in_a      = gen_opnd(in_sp_dp);
                in_b      = ($urandom_range(0, 7) == 0) ? in_a : gen_opnd(in_sp_dp);
                {in_eq, in_lt, in_le} = 3'($urandom);
                in_tag    = 5'($urandom);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            @(negedge clk);
            if (in_valid && in_ready)
                exp_q.push_back(ref_model(in_op, in_sp_dp, in_a, in_b, in_eq, in_lt, in_le, in_tag));
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL rand_extra: got unexpected result %h tag %h", out_result, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_result, out_fflags, out_tag} !== {e.res, e.flags, e.tag})
                        $display("[TB] FAIL rand_result: got %h/%h/%h expected %h/%h/%h", out_result, out_fflags, out_tag, e.res, e.flags, e.tag);
                    else passes++;
                end
                drained++;
            end
        end
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL rand_lost: got %0d undelivered expected 0", exp_q.size()); else passes++;
        checks++; if (drained < 50) $display("[TB] FAIL rand_throughput: got %0d results expected at least 50", drained); else passes++;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 3'd0; in_sp_dp = 1'b0; in_a = 64'd0; in_b = 64'd0;
        in_eq = 1'b0; in_lt = 1'b0; in_le = 1'b0; in_tag = '0;
        test_reset();
        test_flt_sp();
        test_feq_nan();
        test_fminmax_zero();
        test_bad_box();
        test_reserved();
        test_back_to_back();
        test_reset_flush();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
